ccff_chain_loader: RTL

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_chain_loader.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
//
// Purpose:
//   Streams a bitstream into a serial configuration flip-flop chain (CCFF)
//   MSB-first, one bit per prog_clk edge. At the same time it captures what
//   falls out of the chain tail and returns it as readback words.
//
//   The load is bit_count bits long. Words are fetched one at a time. Any
//   bits of a final partial word beyond bit_count are never shifted. One
//   bubble cycle (FETCH) separates consecutive words.
//
// Ports:
//   prog_clk       in   only clock, rising edge
//   prog_reset     in   synchronous active-high reset, aborts any load
//   start          in   load request, sampled only in IDLE
//   bit_count      in   LEN_W  number of config bits, latched on start
//   s_valid        in   bitstream word valid
//   s_ready        out  loader accepts a word (FETCH only)
//   s_data         in   WORD_W bitstream word, MSB shifted first
//   ccff_head      out  serial data into the chain head
//   ccff_shift_en  out  chain advances on an edge only where this is 1
//   ccff_tail      in   serial data out of the chain tail
//   rb_valid       out  one-cycle pulse, rb_data valid
//   rb_data        out  WORD_W readback word, left-aligned when partial
//   busy           out  high in every state except IDLE
//   done           out  one-cycle pulse at the end of a load
//   dbg_state      out  2-bit encoding of the FSM state:
//                       0 IDLE, 1 FETCH, 2 SHIFT, 3 DONE
//
// Handshake:
//   The word stream uses strict valid/ready. A word transfers on a rising
//   edge where s_valid && s_ready. s_ready does not depend on s_valid.
//   The source must keep s_data stable while s_valid is high and the
//   transfer has not happened. Readback has no backpressure.
// ---------------------------------------------------------------------------
module ccff_chain_loader #(
  parameter int WORD_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  bit_count,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [LEN_W-1:0] WORD_W_L = LEN_W'(WORD_W);
  localparam logic [LEN_W-1:0] ONE_L    = LEN_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   sr_q, sr_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [LEN_W-1:0]    word_left_q, word_left_d;
  logic [WORD_W-1:0]   rb_sr_q, rb_sr_d;
  logic [CNT_W-1:0]    rb_cnt_q, rb_cnt_d;
  logic [WORD_W-1:0]   rb_data_q, rb_data_d;
  logic                rb_valid_q, rb_valid_d;
  logic [WORD_W-1:0]   rb_word;

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    remaining_d = remaining_q;
    word_left_d = word_left_q;
    rb_sr_d     = rb_sr_q;
    rb_cnt_d    = rb_cnt_q;
    rb_data_d   = rb_data_q;
    rb_valid_d  = 1'b0;
    rb_word     = rb_sr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rb_sr_d  = '0;
          rb_cnt_d = '0;
          if (bit_count != '0) begin
            remaining_d = bit_count;
            state_d     = ST_FETCH;
          end else begin
            // An empty load still produces its done pulse.
            state_d = ST_DONE;
          end
        end
      end

      ST_FETCH: begin
        if (s_valid) begin
          sr_d = s_data;
          // The last word may be partial; only the bits still owed get shifted.
          word_left_d = (remaining_q < WORD_W_L) ? remaining_q : WORD_W_L;
          state_d     = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        sr_d        = sr_q << 1;
        remaining_d = remaining_q - ONE_L;
        word_left_d = word_left_q - ONE_L;

        // Drop the tail sample into the next free slot, counting down from
        // the MSB. Partial words then come out left-aligned with zero LSBs.
        for (int i = 0; i < WORD_W; i++) begin
          if (rb_cnt_q == CNT_W'(WORD_W - 1 - i)) begin
            rb_word[i] = ccff_tail;
          end
        end

        // word_left reaching zero closes both the input word and the
        // readback word, because every fetched word is readback-aligned.
        if (word_left_q == ONE_L) begin
          rb_data_d  = rb_word;
          rb_valid_d = 1'b1;
          rb_sr_d    = '0;
          rb_cnt_d   = '0;
        end else begin
          rb_sr_d  = rb_word;
          rb_cnt_d = rb_cnt_q + CNT_W'(1);
        end

        if (remaining_q == ONE_L) begin
          state_d = ST_DONE;
        end else if (word_left_q == ONE_L) begin
          state_d = ST_FETCH;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      remaining_q <= '0;
      word_left_q <= '0;
      rb_sr_q     <= '0;
      rb_cnt_q    <= '0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      remaining_q <= remaining_d;
      word_left_q <= word_left_d;
      rb_sr_q     <= rb_sr_d;
      rb_cnt_q    <= rb_cnt_d;
      rb_data_q   <= rb_data_d;
      rb_valid_q  <= rb_valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from the state register, so reset clears them at once
  // -------------------------------------------------------------------------
  always_comb begin
    s_ready       = (state_q == ST_FETCH);
    ccff_shift_en = (state_q == ST_SHIFT);
    ccff_head     = (state_q == ST_SHIFT) ? sr_q[WORD_W-1] : 1'b0;
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_DONE);
    rb_valid      = rb_valid_q;
    rb_data       = rb_data_q;
    dbg_state     = state_q;
  end

endmodule
